shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_serializer.sv | 138 +++++++++++++
 tb/tb_shift_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Parallel-to-serial shifter with a selectable bit order per word. A word is
// accepted on load_valid & load_ready, then one bit is presented on serial_out
// and consumed on every cycle with shift_en high. A new word can be accepted on
// the cycle the last bit is consumed, giving gap-free back-to-back streaming.
//
// Configuration macro:
//   SHIFT_SERIALIZER_SIPO_EN - adds serial_in / par_out so the register also
//                              captures incoming serial bits (full duplex).
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   load_data  - parallel word to serialise (WIDTH bits)
//   load_valid - load_data and lsb_first are valid this cycle
//   load_ready - block accepts a word this cycle
//   lsb_first  - bit order of the word being loaded (1 = LSB first)
//   shift_en   - consume the current serial bit and advance
//   serial_out - current serial bit
//   busy       - a word is being serialised
//   done       - one-cycle pulse after the last bit of a word is consumed
//   serial_in  - (SIPO only) bit shifted into the vacated register position
//   par_out    - (SIPO only) current contents of the shift register
// -----------------------------------------------------------------------------
module shift_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             busy,
    output logic             done
`ifdef SHIFT_SERIALIZER_SIPO_EN
    ,
    input  logic             serial_in,
    output logic [WIDTH-1:0] par_out
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             mode, mode_next;
    logic             done_next;
    logic             fill_bit;

`ifdef SHIFT_SERIALIZER_SIPO_EN
    assign fill_bit = serial_in;
    assign par_out  = shreg;
`else
    assign fill_bit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: shift register, bit counter, bit-order mode and the
    // registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            done  <= 1'b0;
        end else begin
            shreg <= shreg_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
            done  <= done_next;
        end
    end

    // Next-state and output logic. The last-bit cycle also shifts so that in
    // SIPO builds all WIDTH incoming bits land in the register; a load on the
    // same cycle overrides that shift and keeps the FSM in SHIFT.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        mode_next  = mode;
        done_next  = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        serial_out = 1'b0;

        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                busy       = 1'b1;
                serial_out = mode ? shreg[0] : shreg[WIDTH-1];
                if (shift_en) begin
                    shreg_next = mode ? {fill_bit, shreg[WIDTH-1:1]}
                                      : {shreg[WIDTH-2:0], fill_bit};
                    if (cnt == '0) begin
                        done_next  = 1'b1;
                        load_ready = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load_valid && load_ready) begin
            shreg_next = load_data;
            mode_next  = lsb_first;
            cnt_next   = CW'(WIDTH - 1);
            state_next = SHIFT;
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_shift_serializer
//
// Directed bench for shift_serializer (WIDTH = 8). Each accepted word pushes its
// expected serial bits (plus a last-bit marker) onto a scoreboard queue; every
// consumed bit pops the queue and is compared with serial_out. busy, load_ready
// and done are predicted from the scoreboard each cycle.
// Build with SHIFT_SERIALIZER_SIPO_EN to also exercise the serial-capture path.
// -----------------------------------------------------------------------------
module tb_shift_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             lsb_first;
    logic             shift_en;
    logic             serial_out;
    logic             busy;
    logic             done;
`ifdef SHIFT_SERIALIZER_SIPO_EN
    logic             serial_in;
    logic [WIDTH-1:0] par_out;
`endif

    int checks   = 0;
    int failures = 0;

    bit exp_bits[$];
    bit exp_last[$];
    bit done_exp = 1'b0;
    bit accepted;
    int done_count;
    int busy_count;
    int ready_busy_count;
    int n;

    shift_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
`ifdef SHIFT_SERIALIZER_SIPO_EN
        ,
        .serial_in  (serial_in),
        .par_out    (par_out)
`endif
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] d,
                                 input logic lsb, input logic sen);
        load_valid = lv;
        load_data  = d;
        lsb_first  = lsb;
        shift_en   = sen;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w, input logic lsb);
        for (int i = 0; i < WIDTH; i++) begin
            exp_bits.push_back(lsb ? w[i] : w[WIDTH-1-i]);
            exp_last.push_back(i == WIDTH - 1);
        end
    endtask

    // One clock cycle: check outputs at the falling edge against the
    // scoreboard, update the scoreboard for the coming rising edge, then
    // return just after that edge so the caller can drive new inputs.
    task automatic clockCycle();
        bit busy_e, last_e, ready_e, bit_e;
        @(negedge clk);
        busy_e  = (exp_bits.size() != 0);
        last_e  = busy_e && shift_en && exp_last[0];
        ready_e = !busy_e || last_e;
        bit_e   = busy_e ? exp_bits[0] : 1'b0;
        checkOutput("busy", busy, busy_e);
        checkOutput("load_ready", load_ready, ready_e);
        checkOutput("done", done, done_exp);
        checkOutput("serial_out", serial_out, bit_e);
        if (busy === 1'b1) busy_count++;
        if (done === 1'b1) done_count++;
        if (busy === 1'b1 && load_ready === 1'b1) ready_busy_count++;
        accepted = 1'b0;
        if (busy_e && shift_en) begin
            void'(exp_bits.pop_front());
            void'(exp_last.pop_front());
        end
        done_exp = last_e;
        if (load_valid && ready_e) begin
            pushWord(load_data, lsb_first);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
`ifdef SHIFT_SERIALIZER_SIPO_EN
        serial_in = 1'b0;
`endif

        // Reset state
        #12;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_serial_out", serial_out, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_load_ready", load_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clockCycle();

        // 0xA5 MSB first; lsb_first wiggles mid-word and must be ignored
        done_count = 0;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
        clockCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, i[0], 1'b1);
            clockCycle();
        end
        checkOutput("a5_msb_done_count", done_count, 1);

        // 0xA5 LSB first; busy for exactly WIDTH cycles
        busy_count = 0;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
        clockCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, ~i[0], 1'b1);
            clockCycle();
        end
        checkOutput("a5_lsb_busy_cycles", busy_count, 8);

        // 0x0F with shift_en stalls; loads offered during stalls are ignored
        done_count = 0;
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b1);
        clockCycle();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(!i[0] && (i < 15), 8'h55, 1'b1, i[0]);
            clockCycle();
        end
        checkOutput("stall_done_count", done_count, 1);

        // Back-to-back 0x81 then 0x3C with load_valid held
        done_count       = 0;
        ready_busy_count = 0;
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b1);
        clockCycle();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
        n = 0;
        do begin
            n++;
            clockCycle();
        end while (!accepted && n < 20);
        checkOutput("b2b_accept_latency", n, 8);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            clockCycle();
        end
        checkOutput("b2b_done_count", done_count, 2);
        checkOutput("b2b_ready_while_busy", ready_busy_count, 2);

        // Reset after 3 bits of 0xFF, then immediately load 0x01
        done_count = 0;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        clockCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            clockCycle();
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_serial_out", serial_out, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_load_ready", load_ready, 1'b1);
        exp_bits.delete();
        exp_last.delete();
        done_exp = 1'b0;
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        clockCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            clockCycle();
        end
        checkOutput("post_rst_done_count", done_count, 1);

`ifdef SHIFT_SERIALIZER_SIPO_EN
        // Serial capture: shift 1,1,0,0,1,0,1,0 in while sending 0x00 MSB first
        begin
            logic [7:0] sin_pattern;
            sin_pattern = 8'b1100_1010;
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
            clockCycle();
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
                serial_in = sin_pattern[7-i];
                clockCycle();
            end
            serial_in = 1'b0;
            checkOutput("sipo_par_out", par_out, 8'hCA);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            clockCycle();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
